// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared ALU control code and multiply FSM encodings
package mul_sequencer_pkg;
   localparam logic [3:0] ALU_CTL_MUL = 4'b1011;
   localparam logic [1:0] MUL_ST_IDLE = 2'd0;
   localparam logic [1:0] MUL_ST_BUSY = 2'd1;
   localparam logic [1:0] MUL_ST_DONE = 2'd2;
endpackage

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp: shift-add multiply datapath keeping the low XLEN product bits
module mul_shift_add_dp #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] mcand_i,
   input  logic [XLEN-1:0] mplr_i,
   output logic [XLEN-1:0] acc_o,
   output logic            mplr_zero_o,
   output logic            cnt_last_o
);
   localparam int CW = $clog2(XLEN);
   logic [XLEN-1:0] r_acc, r_mcand, r_mplr;
   logic [CW-1:0]   r_cnt;
   // load clears the accumulator; each step adds the shifted multiplicand when the multiplier LSB is set
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_cnt   <= '0;
      end else if (load_i) begin
         r_acc   <= '0;
         r_mcand <= mcand_i;
         r_mplr  <= mplr_i;
         r_cnt   <= '0;
      end else if (step_i) begin
         r_acc   <= r_mplr[0] ? r_acc + r_mcand : r_acc;
         r_mcand <= r_mcand << 1;
         r_mplr  <= r_mplr >> 1;
         r_cnt   <= r_cnt + 1'b1;
      end
   end
   assign acc_o       = r_acc;
   assign mplr_zero_o = (r_mplr == '0);
   assign cnt_last_o  = (r_cnt == CW'(XLEN - 1));
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: EX-stage multi-cycle mul controller that stalls the pipe until the product is ready
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [3:0]      ALUCtl_i,
   input  logic            Valid_i,
   input  logic            Flush_i,
   input  logic [XLEN-1:0] RS1_i,
   input  logic [XLEN-1:0] RS2_i,
   output logic [XLEN-1:0] Result_o,
   output logic            Done_o,
   output logic            Stall_o
);
   logic [1:0] r_state, w_next;
   logic       w_start, w_load, w_step, w_mplr_zero, w_cnt_last;

   assign w_start = Valid_i & (ALUCtl_i == ALU_CTL_MUL) & ~Flush_i;
   assign w_load  = (r_state == MUL_ST_IDLE) & w_start;
   assign w_step  = (r_state == MUL_ST_BUSY) & ~w_mplr_zero & ~Flush_i;

   // next state: flush always wins; BUSY ends on an exhausted multiplier or the last bit
   always_comb
      w_next = Flush_i                   ? MUL_ST_IDLE :
               (r_state == MUL_ST_IDLE)  ? (w_start ? MUL_ST_BUSY : MUL_ST_IDLE) :
               (r_state == MUL_ST_BUSY)  ? ((w_mplr_zero | w_cnt_last) ? MUL_ST_DONE : MUL_ST_BUSY) :
                                           MUL_ST_IDLE;

   // state register; reset aborts any op in flight
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) r_state <= MUL_ST_IDLE;
      else       r_state <= w_next;

   assign Done_o  = (r_state == MUL_ST_DONE);
   assign Stall_o = ~rst_i & (w_load | (r_state == MUL_ST_BUSY));

   mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (w_load),
      .step_i      (w_step),
      .mcand_i     (RS1_i),
      .mplr_i      (RS2_i),
      .acc_o       (Result_o),
      .mplr_zero_o (w_mplr_zero),
      .cnt_last_o  (w_cnt_last)
   );
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed scoreboard bench for the multi-cycle mul sequencer
module tb_mul_sequencer;
   import mul_sequencer_pkg::*;
   logic        clk = 0;
   logic        rst = 1;
   logic [3:0]  ctl = '0;
   logic        valid = 0;
   logic        flush = 0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic [31:0] result;
   logic        done, stall;
   logic [31:0] sb[$];
   logic [31:0] dropped;
   int          total = 0;
   int          bad = 0;

   mul_sequencer #(.XLEN(32)) dut (
      .clk_i(clk), .rst_i(rst), .ALUCtl_i(ctl), .Valid_i(valid), .Flush_i(flush),
      .RS1_i(rs1), .RS2_i(rs2), .Result_o(result), .Done_o(done), .Stall_o(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int done_cycle(input logic [31:0] b);
      int k = -1;
      for (int i = 0; i < 32; i++) if (b[i]) k = i;
      return (k < 31) ? k + 3 : 33;
   endfunction

   // drive a mul in the current (negedge) cycle T0 and record its expected product
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      valid = 1; ctl = ALU_CTL_MUL; rs1 = a; rs2 = b;
      #1;
      chk("stall_t0", {31'd0, stall}, 32'd1);
      sb.push_back(a * b);
   endtask

   // follow the op cycle by cycle until Done_o, checking stall and done timing
   task automatic wait_done(input int exp_t);
      logic [31:0] e;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         valid = 0;
         if (done) begin
            e = sb.pop_front();
            chk("done_cycle", t, exp_t);
            chk("result", result, e);
            chk("stall_at_done", {31'd0, stall}, 32'd0);
            return;
         end
         if (stall !== 1'b1) chk("stall_busy", {31'd0, stall}, 32'd1);
      end
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) dropped = sb.pop_front();
   endtask

   initial begin
      @(negedge clk);
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      rst = 0;
      @(negedge clk);
      // non-mul control code must not stall
      valid = 1; ctl = ALU_CTL_MUL ^ 4'b0001;
      #1;
      chk("other_op_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      valid = 0;
      // reset in the middle of a long multiply
      start_op(32'd7, 32'h8000_0000);
      for (int t = 1; t <= 10; t++) begin
         @(negedge clk);
         valid = 0;
      end
      rst = 1;
      #1;
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      dropped = sb.pop_front();
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      start_op(32'd5, 32'd6);
      wait_done(done_cycle(32'd6));
      // basic 7x6 from the table
      @(negedge clk);
      chk("done_one_pulse", {31'd0, done}, 32'd0);
      chk("result_held", result, 32'd30);
      start_op(32'd7, 32'd6);
      wait_done(5);
      // worst case: multiplier MSB set
      @(negedge clk);
      start_op(32'hFFFF_FFFF, 32'h8000_0000);
      wait_done(33);
      // best case: zero multiplier
      @(negedge clk);
      start_op(32'h1234_5678, 32'd0);
      wait_done(2);
      // back-to-back: second mul sits in EX during DONE and starts fresh afterwards
      @(negedge clk);
      start_op(32'd3, 32'd5);
      wait_done(5);
      valid = 1; ctl = ALU_CTL_MUL; rs1 = 32'h0000_FFFF; rs2 = 32'h0001_0001;
      @(negedge clk);
      start_op(32'h0000_FFFF, 32'h0001_0001);
      wait_done(19);
      @(negedge clk);
      chk("b2b_no_dup", {31'd0, done}, 32'd0);
      chk("b2b_idle_stall", {31'd0, stall}, 32'd0);
      // flush at T3: two steps taken, then squashed
      start_op(32'd9, 32'hFF);
      @(negedge clk);
      valid = 0;
      @(negedge clk);
      @(negedge clk);
      flush = 1;
      #1;
      chk("flush_t3_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      flush = 0;
      chk("flush_t4_stall", {31'd0, stall}, 32'd0);
      chk("flush_t4_done", {31'd0, done}, 32'd0);
      chk("flush_acc_kept", result, 32'd27);
      dropped = sb.pop_front();
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (done !== 1'b0 || stall !== 1'b0) chk("flush_quiet", {30'd0, done, stall}, 32'd0);
      end
      // start and flush together: no stall, never starts
      valid = 1; ctl = ALU_CTL_MUL; rs1 = 32'd4; rs2 = 32'd4; flush = 1;
      #1;
      chk("start_flush_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      flush = 0; valid = 0;
      chk("start_flush_idle", {31'd0, stall}, 32'd0);
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (done !== 1'b0) chk("start_flush_nodone", {31'd0, done}, 32'd0);
      end
      chk("start_flush_acc", result, 32'd27);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
